i2s_receiver: RTL and testbench

//  I2S slave receiver and the downstream stage of i2s_master.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_sync_edge.sv | 33 +++
 rtl/i2s_receiver.sv | 135 +++++++++++++
 tb/tb_i2s_receiver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: frame FSM states and default sample/slot geometry.
package i2s_pkg;

    localparam int unsigned I2S_DATA_W = 24;
    localparam int unsigned I2S_SLOT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LEFT,
        RIGHT
    } state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, with rise/fall pulses on the synced value.
module i2s_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   q_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            q_prev <= 1'b0;
        end else begin
            sync_q[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            q_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q      = sync_q[SYNC_STAGES-1];
    assign rise_c = q & ~q_prev;
    assign fall_c = ~q & q_prev;

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples BCLK/LRCLK/DATA, deserialises 24-bit samples from
// 32-bit slots and presents stereo frames on a valid/ready interface.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W      = I2S_DATA_W,
    parameter int unsigned SLOT_W      = I2S_SLOT_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              i2s_bclk_i,
    input  logic              i2s_lrclk_i,
    input  logic              i2s_data_i,
    output logic [DATA_W-1:0] left_o,
    output logic [DATA_W-1:0] right_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o,
    output logic              frame_err_o
);

    localparam int unsigned CNT_W = $clog2(SLOT_W + 1);

    logic bclk_q, bclk_rise_c, bclk_fall_c;
    logic lr_q, lr_rise_c, lr_fall_c;
    logic data_q, data_rise_c, data_fall_c;
    logic unused_edges;

    state_e            state, state_d;
    logic              lr_prev;
    logic [CNT_W-1:0]  bit_cnt, bit_next_c;
    logic [DATA_W-1:0] shreg, left_hold, sample_c;
    logic              lr_edge_c, last_bit_c, slot_ok_c;
    logic              cap_left_c, frame_done_c, frame_err_c;

    // All three lines share the same synchroniser depth so they stay cycle-aligned.
    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(clk_i), .rst(rst_i), .d(i2s_bclk_i),
        .q(bclk_q), .rise_c(bclk_rise_c), .fall_c(bclk_fall_c)
    );
    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk(clk_i), .rst(rst_i), .d(i2s_lrclk_i),
        .q(lr_q), .rise_c(lr_rise_c), .fall_c(lr_fall_c)
    );
    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk_i), .rst(rst_i), .d(i2s_data_i),
        .q(data_q), .rise_c(data_rise_c), .fall_c(data_fall_c)
    );

    assign unused_edges = ^{bclk_q, bclk_fall_c, lr_rise_c, lr_fall_c, data_rise_c, data_fall_c};

    assign lr_edge_c  = bclk_rise_c && (lr_q != lr_prev);
    assign sample_c   = {shreg[DATA_W-2:0], data_q};
    assign last_bit_c = bclk_rise_c && !lr_edge_c && (bit_cnt == CNT_W'(DATA_W - 1));
    assign slot_ok_c  = (bit_cnt == CNT_W'(SLOT_W - 1));

    always_comb begin
        bit_next_c = bit_cnt;
        if (lr_edge_c)                        bit_next_c = '0;
        else if (bit_cnt != CNT_W'(SLOT_W))   bit_next_c = bit_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d      = state;
        cap_left_c   = 1'b0;
        frame_done_c = 1'b0;
        frame_err_c  = 1'b0;
        case (state)
            IDLE: if (enable_i) state_d = SYNC;
            SYNC: if (lr_edge_c && !lr_q) state_d = LEFT;
            LEFT, RIGHT: begin
                if (lr_edge_c) begin
                    frame_err_c = !slot_ok_c;
                    // A falling edge always starts a fresh left slot, even after a bad slot.
                    if (!lr_q)                            state_d = LEFT;
                    else if (slot_ok_c && state == LEFT)  state_d = RIGHT;
                    else                                  state_d = SYNC;
                end else if (last_bit_c) begin
                    cap_left_c   = (state == LEFT);
                    frame_done_c = (state == RIGHT);
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable_i) begin
            state_d      = IDLE;
            cap_left_c   = 1'b0;
            frame_done_c = 1'b0;
            frame_err_c  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lr_prev     <= 1'b0;
            bit_cnt     <= '0;
            shreg       <= '0;
            left_hold   <= '0;
            left_o      <= '0;
            right_o     <= '0;
            valid_o     <= 1'b0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (bclk_rise_c) begin
                lr_prev <= lr_q;
                bit_cnt <= bit_next_c;
                if (!lr_edge_c && bit_cnt < CNT_W'(DATA_W)) shreg <= sample_c;
            end
            if (cap_left_c)       left_hold <= sample_c;
            else if (frame_err_c) left_hold <= '0;
            frame_err_o <= frame_err_c;
            // Output stage: load when empty or draining this cycle, otherwise flag the drop.
            if (frame_done_c) begin
                if (!valid_o || ready_i) begin
                    left_o  <= left_hold;
                    right_o <= sample_c;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed testbench for i2s_receiver: an I2S transmitter BFM drives frames, tasks check results.
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        i2s_bclk_i = 1'b0;
    logic        i2s_lrclk_i = 1'b0;
    logic        i2s_data_i = 1'b0;
    logic [23:0] left_o, right_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        overrun_o;
    logic        frame_err_o;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] acc_l[$];
    logic [23:0] acc_r[$];
    int          err_pulses = 0;

    always #10 clk = ~clk;

    i2s_receiver dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
        .i2s_bclk_i(i2s_bclk_i), .i2s_lrclk_i(i2s_lrclk_i), .i2s_data_i(i2s_data_i),
        .left_o(left_o), .right_o(right_o), .valid_o(valid_o), .ready_i(ready_i),
        .overrun_o(overrun_o), .frame_err_o(frame_err_o)
    );

    // Record accepted frames and frame-error pulses
    always @(negedge clk) begin
        if (valid_o && ready_i) begin
            acc_l.push_back(left_o);
            acc_r.push_back(right_o);
        end
        if (frame_err_o) err_pulses++;
    end

    // One BCLK period (8 clk): data/LRCLK change while BCLK low, rising edge mid-period
    task automatic send_bit(input logic lr, input logic b);
        i2s_lrclk_i = lr;
        i2s_data_i  = b;
        repeat (4) @(posedge clk);
        #1 i2s_bclk_i = 1'b1;
        repeat (4) @(posedge clk);
        #1 i2s_bclk_i = 1'b0;
    endtask

    // Slot bit 0 and bits after 24 are driven 1 so any leakage into the sample shows up
    task automatic send_slot(input logic lr, input logic [23:0] s, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (i >= 1 && i <= 24) send_bit(lr, s[24-i]);
            else                   send_bit(lr, 1'b1);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    task automatic test_reset();
        enable_i = 1'b1;
        ready_i  = 1'b1;
        rst_i    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (left_o !== 24'h0) begin miscompares++; $display("FAIL reset_left: got %h want 000000", left_o); end
        vectors++; if (right_o !== 24'h0) begin miscompares++; $display("FAIL reset_right: got %h want 000000", right_o); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
        vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", frame_err_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_loopback();
        logic [23:0] tl[3];
        logic [23:0] tr[3];
        int n0, e0;
        tl = '{24'h9A5AC3, 24'h000000, 24'h800001};
        tr = '{24'h9A5AC3, 24'hFFFFFF, 24'h7FFFFE};
        // A right slot first so the first left slot begins at an LRCLK fall
        send_slot(1'b1, 24'h0, 32);
        n0 = acc_l.size();
        e0 = err_pulses;
        for (int i = 0; i < 3; i++) send_frame(tl[i], tr[i]);
        vectors++; if (acc_l.size() !== n0 + 3) begin miscompares++; $display("FAIL loop_count: got %0d want %0d", acc_l.size() - n0, 3); end
        for (int i = 0; i < 3; i++) begin
            if (acc_l.size() > n0 + i) begin
                vectors++; if (acc_l[n0+i] !== tl[i]) begin miscompares++; $display("FAIL loop_left%0d: got %h want %h", i, acc_l[n0+i], tl[i]); end
                vectors++; if (acc_r[n0+i] !== tr[i]) begin miscompares++; $display("FAIL loop_right%0d: got %h want %h", i, acc_r[n0+i], tr[i]); end
            end
        end
        vectors++; if (err_pulses !== e0) begin miscompares++; $display("FAIL loop_frame_err: got %0d pulses want 0", err_pulses - e0); end
        vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL loop_overrun: got %b want 0", overrun_o); end
    endtask

    task automatic test_frame_err();
        int n0, e0;
        n0 = acc_l.size();
        e0 = err_pulses;
        send_slot(1'b0, 24'h121212, 31);
        send_slot(1'b1, 24'h343434, 32);
        vectors++; if (err_pulses !== e0 + 1) begin miscompares++; $display("FAIL short_slot_err: got %0d pulses want 1", err_pulses - e0); end
        vectors++; if (acc_l.size() !== n0) begin miscompares++; $display("FAIL short_slot_dropped: got %0d frames want 0", acc_l.size() - n0); end
        send_frame(24'h565656, 24'h787878);
        vectors++; if (acc_l.size() !== n0 + 1) begin miscompares++; $display("FAIL recover_count: got %0d want 1", acc_l.size() - n0); end
        if (acc_l.size() > n0) begin
            vectors++; if (acc_l[n0] !== 24'h565656) begin miscompares++; $display("FAIL recover_left: got %h want 565656", acc_l[n0]); end
            vectors++; if (acc_r[n0] !== 24'h787878) begin miscompares++; $display("FAIL recover_right: got %h want 787878", acc_r[n0]); end
        end
        vectors++; if (err_pulses !== e0 + 1) begin miscompares++; $display("FAIL recover_err: got %0d pulses want 1", err_pulses - e0); end
    endtask

    task automatic test_enable();
        int n0;
        n0 = acc_l.size();
        enable_i = 1'b0;
        send_frame(24'hAAAAAA, 24'hBBBBBB);
        vectors++; if (acc_l.size() !== n0) begin miscompares++; $display("FAIL disabled_frames: got %0d want 0", acc_l.size() - n0); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL disabled_valid: got %b want 0", valid_o); end
        enable_i = 1'b1;
        send_frame(24'hCCCCCC, 24'hDDDDDD);
        vectors++; if (acc_l.size() !== n0 + 1) begin miscompares++; $display("FAIL reenable_count: got %0d want 1", acc_l.size() - n0); end
        if (acc_l.size() > n0) begin
            vectors++; if (acc_l[n0] !== 24'hCCCCCC) begin miscompares++; $display("FAIL reenable_left: got %h want cccccc", acc_l[n0]); end
            vectors++; if (acc_r[n0] !== 24'hDDDDDD) begin miscompares++; $display("FAIL reenable_right: got %h want dddddd", acc_r[n0]); end
        end
    endtask

    task automatic test_backpressure();
        int n0;
        n0 = acc_l.size();
        ready_i = 1'b0;
        send_frame(24'h111111, 24'h222222);
        vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_valid1: got %b want 1", valid_o); end
        vectors++; if (left_o !== 24'h111111) begin miscompares++; $display("FAIL bp_left1: got %h want 111111", left_o); end
        vectors++; if (right_o !== 24'h222222) begin miscompares++; $display("FAIL bp_right1: got %h want 222222", right_o); end
        vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL bp_overrun1: got %b want 0", overrun_o); end
        send_frame(24'h333333, 24'h444444);
        vectors++; if (overrun_o !== 1'b1) begin miscompares++; $display("FAIL bp_overrun2: got %b want 1", overrun_o); end
        vectors++; if (left_o !== 24'h111111) begin miscompares++; $display("FAIL bp_left_held: got %h want 111111", left_o); end
        vectors++; if (right_o !== 24'h222222) begin miscompares++; $display("FAIL bp_right_held: got %h want 222222", right_o); end
        @(posedge clk);
        #1 ready_i = 1'b1;
        @(posedge clk);
        #1 ready_i = 1'b0;
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_drain_valid: got %b want 0", valid_o); end
        vectors++; if (left_o !== 24'h111111) begin miscompares++; $display("FAIL bp_hold_after_accept: got %h want 111111", left_o); end
        vectors++; if (acc_l.size() !== n0 + 1) begin miscompares++; $display("FAIL bp_accept_count: got %0d want 1", acc_l.size() - n0); end
        if (acc_l.size() > n0) begin
            vectors++; if (acc_r[n0] !== 24'h222222) begin miscompares++; $display("FAIL bp_accept_right: got %h want 222222", acc_r[n0]); end
        end
        vectors++; if (overrun_o !== 1'b1) begin miscompares++; $display("FAIL bp_overrun_sticky: got %b want 1", overrun_o); end
    endtask

    task automatic test_reset_mid();
        int n0, e0;
        ready_i = 1'b1;
        send_slot(1'b0, 24'h555555, 32);
        send_slot(1'b1, 24'h666666, 10);
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (left_o !== 24'h0) begin miscompares++; $display("FAIL midrst_left: got %h want 000000", left_o); end
        vectors++; if (right_o !== 24'h0) begin miscompares++; $display("FAIL midrst_right: got %h want 000000", right_o); end
        vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL midrst_overrun: got %b want 0", overrun_o); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", valid_o); end
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        n0 = acc_l.size();
        e0 = err_pulses;
        send_slot(1'b1, 24'h0, 22);
        vectors++; if (acc_l.size() !== n0) begin miscompares++; $display("FAIL midrst_no_partial: got %0d want 0", acc_l.size() - n0); end
        send_frame(24'h777777, 24'h888888);
        vectors++; if (acc_l.size() !== n0 + 1) begin miscompares++; $display("FAIL midrst_count: got %0d want 1", acc_l.size() - n0); end
        if (acc_l.size() > n0) begin
            vectors++; if (acc_l[n0] !== 24'h777777) begin miscompares++; $display("FAIL midrst_left_rx: got %h want 777777", acc_l[n0]); end
            vectors++; if (acc_r[n0] !== 24'h888888) begin miscompares++; $display("FAIL midrst_right_rx: got %h want 888888", acc_r[n0]); end
        end
        vectors++; if (err_pulses !== e0) begin miscompares++; $display("FAIL midrst_err: got %0d pulses want 0", err_pulses - e0); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_frame_err();
        test_enable();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
